// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store, accepted
// over req/ready, answered with a one-cycle rvalid pulse after a fixed latency.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U    = 32'(DEPTH_WORDS);
    localparam bit          SINGLE_LAT = (LATENCY == 1);
    localparam logic [3:0]  CNT_LOAD   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             eval_we;
    logic [31:0]      eval_addr;
    logic [31:0]      eval_wdata;
    logic [IDX_W-1:0] eval_idx;
    logic             eval_bad;
    logic             mem_we;

    // With LATENCY=1 the RESP-entry edge is the acceptance edge itself, so the
    // request is evaluated straight from the ports rather than the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eval_we    = we_i;
            eval_addr  = addr_i;
            eval_wdata = wdata_i;
        end else begin
            eval_we    = we_q;
            eval_addr  = addr_q;
            eval_wdata = wdata_q;
        end
        eval_idx = eval_addr[IDX_W+1:2];
        eval_bad = (eval_addr[1:0] != 2'b00) || ({2'b00, eval_addr[31:2]} >= DEPTH_U);
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (SINGLE_LAT) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Response and any store commit happen only on the edge entering RESP.
        if (state_d == ST_RESP) begin
            rvalid_d = 1'b1;
            if (eval_bad) begin
                err_d   = 1'b1;
                rdata_d = 32'h0;
            end else if (eval_we) begin
                mem_we  = 1'b1;
                err_d   = 1'b0;
                rdata_d = 32'h0;
            end else begin
                err_d   = 1'b0;
                rdata_d = mem_q[eval_idx];
            end
        end
    end

    // NOTE: the storage must read as zero after reset, so it is a resettable flop
    // array (not an inferred RAM) and every word is cleared in the reset branch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            if (mem_we) begin
                mem_q[eval_idx] <= eval_wdata;
            end
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
